// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle for one data-memory port.
// The requester drives the request fields; the arbiter returns grant, ack and read data.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, adr, wdata,
    input  gnt, ack, rdata
  );

  modport slave (
    input  req, we, adr, wdata,
    output gnt, ack, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data RAM between the load/store path (port a) and the host loader (port b).
// Grants at most one access per cycle; ack and read data follow one cycle after grant.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave a,
  dmem_arbiter_if.slave b,
  input  logic          b_lock,
  output logic          ram_we,
  output logic [AW-1:0] ram_adr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int            BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  typedef enum logic {OWN_A, OWN_B} owner_e;

  owner_e        last;
  logic [BW-1:0] burst_cnt;
  logic          a_win;
  logic          b_win;
  logic          lock_hold;

  // B keeps the RAM through contention only while its capped burst has room left.
  assign lock_hold = (last == OWN_B) && b_lock && (burst_cnt < BURST_MAX);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    if (!reset) begin
      if (a.req && b.req) begin
        if (lock_hold || last == OWN_A) b_win = 1'b1;
        else                            a_win = 1'b1;
      end else begin
        a_win = a.req;
        b_win = b.req;
      end
    end
  end

  assign a.gnt = a_win;
  assign b.gnt = b_win;

  always_comb begin
    ram_we  = 1'b0;
    ram_adr = '0;
    ram_din = '0;
    if (a_win) begin
      ram_we  = a.we;
      ram_adr = a.adr;
      ram_din = a.wdata;
    end else if (b_win) begin
      ram_we  = b.we;
      ram_adr = b.adr;
      ram_din = b.wdata;
    end
  end

  // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      last      <= OWN_B;
      burst_cnt <= '0;
      a.ack     <= 1'b0;
      b.ack     <= 1'b0;
      a.rdata   <= '0;
      b.rdata   <= '0;
    end else begin
      a.ack <= a_win;
      b.ack <= b_win;

      if (a_win) begin
        last    <= OWN_A;
        a.rdata <= a.we ? '0 : ram_dout;
      end

      if (b_win) begin
        last    <= OWN_B;
        b.rdata <= b.we ? '0 : ram_dout;
      end

      // Only B grants taken while A is waiting count toward the cap.
      if (b_win && a.req) begin
        if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
      end else begin
        burst_cnt <= '0;
      end
    end
  end

  grant_onehot: assert property (@(posedge clk) !(a_win && b_win));
  burst_bound:  assert property (@(posedge clk) disable iff (reset) burst_cnt <= BURST_MAX);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed RAM model.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        b_lock;
  logic        ram_we;
  logic [31:0] ram_adr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [31:0] mem [0:255];

  int tests_run;
  int tests_failed;

  dmem_arbiter_if #(.AW(32), .DW(32)) a_if ();
  dmem_arbiter_if #(.AW(32), .DW(32)) b_if ();

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a_if.slave),
    .b        (b_if.slave),
    .b_lock   (b_lock),
    .ram_we   (ram_we),
    .ram_adr  (ram_adr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: word i preloads to 0xA000_0000 + i while reset is high.
  assign ram_dout = mem[ram_adr[9:2]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
    end else if (ram_we) begin
      mem[ram_adr[9:2]] <= ram_din;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    b_lock     = 1'b0;
    a_if.req   = 1'b1;  a_if.we = 1'b1;  a_if.adr = 32'h8;  a_if.wdata = 32'h11;
    b_if.req   = 1'b1;  b_if.we = 1'b1;  b_if.adr = 32'hC;  b_if.wdata = 32'h22;
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      tests_run++;
      if ({a_if.gnt, b_if.gnt, ram_we} !== 3'b000) begin
        tests_failed++;
        $display("FAIL reset_gnt cycle %0d: a_gnt/b_gnt/ram_we=%b expected 000", c, {a_if.gnt, b_if.gnt, ram_we});
      end
      tests_run++;
      if ({a_if.ack, b_if.ack} !== 2'b00 || a_if.rdata !== 32'h0 || b_if.rdata !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_regs cycle %0d: acks=%b a_rdata=%h b_rdata=%h expected 0", c, {a_if.ack, b_if.ack}, a_if.rdata, b_if.rdata);
      end
    end
    reset   = 1'b0;
    a_if.we = 1'b0;
    #1;
    tests_run++;
    if (a_if.gnt !== 1'b1 || b_if.gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_first_tie: a_gnt=%b b_gnt=%b expected a_gnt=1 b_gnt=0", a_if.gnt, b_if.gnt);
    end
    tests_run++;
    if (ram_adr !== 32'h8 || ram_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_first_ram: ram_adr=%h ram_we=%b expected 00000008/0", ram_adr, ram_we);
    end
    tick();
    a_if.req = 1'b0;
    b_if.req = 1'b0;
    #1;
    tests_run++;
    if (a_if.ack !== 1'b1 || b_if.ack !== 1'b0 || a_if.rdata !== 32'hA000_0002) begin
      tests_failed++;
      $display("FAIL reset_first_ack: a_ack=%b b_ack=%b a_rdata=%h expected 1/0/a0000002", a_if.ack, b_if.ack, a_if.rdata);
    end
  endtask

  task automatic test_single_port();
    tick();
    b_if.req = 1'b1; b_if.we = 1'b1; b_if.adr = 32'h10; b_if.wdata = 32'hDEAD_BEEF;
    #1;
    tests_run++;
    if (b_if.gnt !== 1'b1 || a_if.gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_wr_gnt: b_gnt=%b a_gnt=%b expected 1/0", b_if.gnt, a_if.gnt);
    end
    tests_run++;
    if (ram_we !== 1'b1 || ram_adr !== 32'h10 || ram_din !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL single_wr_ram: we=%b adr=%h din=%h expected 1/00000010/deadbeef", ram_we, ram_adr, ram_din);
    end
    tick();
    b_if.we = 1'b0;
    #1;
    tests_run++;
    if (b_if.ack !== 1'b1 || b_if.rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL single_wr_ack: b_ack=%b b_rdata=%h expected 1/00000000", b_if.ack, b_if.rdata);
    end
    tests_run++;
    if (b_if.gnt !== 1'b1 || ram_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_rd_gnt: b_gnt=%b ram_we=%b expected 1/0", b_if.gnt, ram_we);
    end
    tick();
    b_if.req = 1'b0;
    #1;
    tests_run++;
    if (b_if.ack !== 1'b1 || b_if.rdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL single_rd_ack: b_ack=%b b_rdata=%h expected 1/deadbeef", b_if.ack, b_if.rdata);
    end
    tests_run++;
    if (b_if.gnt !== 1'b0 || ram_we !== 1'b0 || ram_adr !== 32'h0 || ram_din !== 32'h0) begin
      tests_failed++;
      $display("FAIL idle_ram: gnt=%b we=%b adr=%h din=%h expected all 0", b_if.gnt, ram_we, ram_adr, ram_din);
    end
    tick();
    #1;
    tests_run++;
    if (b_if.ack !== 1'b0 || b_if.rdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL single_hold: b_ack=%b b_rdata=%h expected 0/deadbeef", b_if.ack, b_if.rdata);
    end
  endtask

  task automatic test_round_robin();
    logic exp_a;
    tick();
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.adr = 32'h20;
    b_if.req = 1'b1; b_if.we = 1'b0; b_if.adr = 32'h40;
    b_lock   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      #1;
      exp_a = (i % 2 == 0);
      tests_run++;
      if (a_if.gnt !== exp_a || b_if.gnt !== !exp_a) begin
        tests_failed++;
        $display("FAIL rr_gnt cycle %0d: a_gnt=%b b_gnt=%b expected %b/%b", i, a_if.gnt, b_if.gnt, exp_a, !exp_a);
      end
      tests_run++;
      if (ram_adr !== (exp_a ? 32'h20 : 32'h40)) begin
        tests_failed++;
        $display("FAIL rr_adr cycle %0d: ram_adr=%h expected %h", i, ram_adr, exp_a ? 32'h20 : 32'h40);
      end
      if (i > 0) begin
        tests_run++;
        if (a_if.ack !== !exp_a || b_if.ack !== exp_a) begin
          tests_failed++;
          $display("FAIL rr_ack cycle %0d: a_ack=%b b_ack=%b expected %b/%b", i, a_if.ack, b_if.ack, !exp_a, exp_a);
        end
      end
    end
    tick();
    a_if.req = 1'b0;
    b_if.req = 1'b0;
    #1;
    tests_run++;
    if (a_if.ack !== 1'b0 || b_if.ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL rr_last_ack: a_ack=%b b_ack=%b expected 0/1", a_if.ack, b_if.ack);
    end
    tests_run++;
    if (a_if.rdata !== 32'hA000_0008 || b_if.rdata !== 32'hA000_0010) begin
      tests_failed++;
      $display("FAIL rr_rdata: a_rdata=%h b_rdata=%h expected a0000008/a0000010", a_if.rdata, b_if.rdata);
    end
  endtask

  task automatic test_locked_burst();
    tick();
    b_if.req = 1'b1; b_if.we = 1'b0; b_if.adr = 32'h40;
    b_lock   = 1'b1;
    #1;
    tests_run++;
    if (b_if.gnt !== 1'b1) begin
      tests_failed++;
      $display("FAIL burst_start: b_gnt=%b expected 1", b_if.gnt);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) begin
        a_if.req = 1'b1; a_if.we = 1'b0; a_if.adr = 32'h20;
      end
      #1;
      tests_run++;
      if (b_if.gnt !== 1'b1 || a_if.gnt !== 1'b0) begin
        tests_failed++;
        $display("FAIL burst_hold cycle %0d: b_gnt=%b a_gnt=%b expected 1/0", i, b_if.gnt, a_if.gnt);
      end
      tests_run++;
      if (dut.burst_cnt !== 4'(i - 1)) begin
        tests_failed++;
        $display("FAIL burst_cnt cycle %0d: burst_cnt=%0d expected %0d", i, dut.burst_cnt, i - 1);
      end
    end
    tick();
    #1;
    tests_run++;
    if (a_if.gnt !== 1'b1 || b_if.gnt !== 1'b0 || dut.burst_cnt !== 4'd8) begin
      tests_failed++;
      $display("FAIL burst_cap: a_gnt=%b b_gnt=%b burst_cnt=%0d expected 1/0/8", a_if.gnt, b_if.gnt, dut.burst_cnt);
    end
    tick();
    a_if.req = 1'b0;
    b_if.req = 1'b0;
    b_lock   = 1'b0;
    #1;
    tests_run++;
    if (dut.burst_cnt !== 4'd0 || a_if.ack !== 1'b1 || a_if.rdata !== 32'hA000_0008) begin
      tests_failed++;
      $display("FAIL burst_end: burst_cnt=%0d a_ack=%b a_rdata=%h expected 0/1/a0000008", dut.burst_cnt, a_if.ack, a_if.rdata);
    end
  endtask

  task automatic test_lock_no_contention();
    tick();
    a_if.req = 1'b0;
    b_if.req = 1'b1; b_if.we = 1'b0; b_if.adr = 32'h40;
    b_lock   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) tick();
      #1;
      tests_run++;
      if (b_if.gnt !== 1'b1 || dut.burst_cnt !== 4'd0) begin
        tests_failed++;
        $display("FAIL lock_alone cycle %0d: b_gnt=%b burst_cnt=%0d expected 1/0", i, b_if.gnt, dut.burst_cnt);
      end
    end
    tick();
    b_if.req = 1'b0;
    b_lock   = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    tick();
    b_if.req = 1'b1; b_if.we = 1'b0; b_if.adr = 32'h40;
    b_lock   = 1'b1;
    #1;
    tests_run++;
    if (b_if.gnt !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_grant: b_gnt=%b expected 1", b_if.gnt);
    end
    tick();
    reset    = 1'b1;
    a_if.req = 1'b1; a_if.we = 1'b1; a_if.adr = 32'h20; a_if.wdata = 32'h55;
    #1;
    tests_run++;
    if ({a_if.gnt, b_if.gnt, ram_we} !== 3'b000) begin
      tests_failed++;
      $display("FAIL midrst_block: a_gnt/b_gnt/ram_we=%b expected 000", {a_if.gnt, b_if.gnt, ram_we});
    end
    tests_run++;
    if (b_if.ack !== 1'b1 || b_if.rdata !== 32'hA000_0010) begin
      tests_failed++;
      $display("FAIL midrst_inflight: b_ack=%b b_rdata=%h expected 1/a0000010", b_if.ack, b_if.rdata);
    end
    tick();
    reset   = 1'b0;
    b_lock  = 1'b0;
    a_if.we = 1'b0;
    #1;
    tests_run++;
    if (b_if.ack !== 1'b0 || b_if.rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL midrst_ack: b_ack=%b b_rdata=%h expected 0/00000000", b_if.ack, b_if.rdata);
    end
    tests_run++;
    if (a_if.gnt !== 1'b1 || b_if.gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_tie: a_gnt=%b b_gnt=%b expected 1/0", a_if.gnt, b_if.gnt);
    end
    tick();
    a_if.req = 1'b0;
    b_if.req = 1'b0;
    #1;
    tests_run++;
    if (a_if.ack !== 1'b1 || a_if.rdata !== 32'hA000_0008) begin
      tests_failed++;
      $display("FAIL midrst_after: a_ack=%b a_rdata=%h expected 1/a0000008", a_if.ack, a_if.rdata);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single_port();
    test_round_robin();
    test_locked_burst();
    test_lock_no_contention();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
